inst_loader: RTL
================

# inst_loader

Boot-time program loader for the single-cycle MIPS core: it receives a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 32-bit instructions. It writes each instruction into the fetcher's instruction store through the fetcher's load port, holding the CPU in reset for the whole transfer. It is the writer side of the fetcher's `load_inst` / `load` / `chip_select` port, which the CPU itself only reads. When the image is complete it releases the CPU, which then starts fetching at `BASE_ADDR`.

## Interface
- `BASE_ADDR`, default 32'h0000_0000 — byte address of the first instruction written; must be word-aligned.
- `MAX_WORDS`, default 1024 — largest accepted image, in words.
- `clk` in 1 — single clock, shared with the CPU.
- `rst` in 1 — synchronous, active-high reset.
- `in_data` in 8 — stream byte.
- `in_valid` in 1 — `in_data` is valid.
- `in_ready` out 1 — loader accepts a byte this cycle.
- `load_addr` out 32 (`addr_t`) — byte address of the current write.
- `load_inst` out 32 (`inst_t`) — assembled instruction.
- `load` out 1 — one-cycle write strobe to the fetcher.
- `chip_select` out 1 — fetcher selected; high only with `load`.
- `cpu_rst` out 1 — reset to the CPU/PC; high until the load finishes.
- `done` out 1 — image loaded, CPU released; sticky.
- `error` out 1 — length rejected; sticky.

## Operation
- Stream format:
  - length header: count N, 16-bit, high byte first;
  - then N×4 bytes; each word is big-endian, so the first byte lands in `[31:24]`.
- States and transitions:
  - LEN_HI → LEN_LO → (N==0: DONE | N>MAX_WORDS: ERROR | else BYTE).
  - BYTE → WRITE after the 4th byte of a word.
  - WRITE → BYTE if words remain, else DONE.
  - DONE and ERROR are terminal; only `rst` exits them.
- Byte acceptance:
  - a byte is taken only when `in_valid && in_ready`;
  - `in_ready` = 1 in LEN_HI, LEN_LO and BYTE; 0 in WRITE, DONE, ERROR and during reset.
- Word assembly: shift left by 8, insert `in_data` at `[7:0]`; a 2-bit byte counter wraps 3→0.
- Write cycle (WRITE):
  - `load` = `chip_select` = 1 for exactly one cycle;
  - `load_inst` = assembled word;
  - `load_addr` = `BASE_ADDR` + 4·k, where k is the word index starting at 0.
  - After the write, `load_addr` += 4 (32-bit wrap, unchecked) and the remaining-word counter (16-bit) decrements.
- Outputs in DONE and ERROR:
  - DONE: `cpu_rst` = 0, `done` = 1, `in_ready` = 0; further bytes are ignored.
  - ERROR: `cpu_rst` stays 1, `error` = 1; no fetcher writes occur.
- Reset values:
  - `in_ready`, `load`, `chip_select`, `done`, `error` = 0;
  - `cpu_rst` = 1;
  - `load_addr` = `BASE_ADDR`, `load_inst` = 0;
  - state = LEN_HI.
- Reset mid-transfer:
  - abandons the partial word and count;
  - already-written words are not erased;
  - the next stream is parsed from its header.
- Gaps: `in_valid` low for any number of cycles stalls the FSM in place; no timeout.

## Timing
- First cycle after `rst` deasserts: `in_ready` = 1.
- Header: minimum 2 cycles.
- Per word: 4 accept cycles plus 1 WRITE cycle, so at most 4 bytes per 5 cycles.
- `load` asserts in the cycle after the 4th byte of a word is accepted.
- `cpu_rst` falls and `done` rises in the cycle after the last WRITE. For N==0 this is the cycle after the LEN_LO byte is accepted.
- `error` rises in the cycle after the LEN_LO byte is accepted.
- Outputs are registered; no combinational path from `in_valid` to `load`.
- `in_ready` is a function of state only, so there is no combinational path from `in_valid` to `in_ready`.

## Structure
- Package `LoaderType`: state enum `loader_state_t` {LEN_HI, LEN_LO, BYTE, WRITE, DONE, ERROR}; constant `LEN_BYTES` = 2.
- Reuse `addr_t` and `inst_t` from `Types`.
- One natural sub-module, `word_assembler`, holding the shift register and byte counter:
  - inputs: `clk`, `rst`, `shift_en`, `byte_in`;
  - outputs: `word`, `full`.
- The top-level FSM, address counter and remaining-word counter live in `inst_loader`.

## Test plan
- N=2, bytes 20 08 00 05, 00 00 00 08 → `load` pulse at addr 0x0 with 0x2008_0005, then at addr 0x4 with 0x0000_0008; `done` = 1 and `cpu_rst` = 0 the cycle after the second write.
- N=0 → no `load` pulses; `done` rises the cycle after the LEN_LO byte is accepted.
- N=1025 with `MAX_WORDS`=1024 → `error` = 1, `cpu_rst` stays 1, `in_ready` = 0, no `load`.
- `in_valid` toggled randomly (≈50%) over a 3-word image → same write sequence and data as the gap-free run; no duplicated or dropped bytes.
- `rst` asserted after 2 bytes of word 1, then a fresh stream with N=1, word 0xDEAD_BEEF → single write of 0xDEAD_BEEF at `BASE_ADDR`.
- `BASE_ADDR`=0x0040_0000, N=3 → writes at 0x0040_0000, 0x0040_0004 and 0x0040_0008; extra bytes after `done` are not accepted (`in_ready` = 0).

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types for the boot loader slice.
// Types carries the core's address/instruction words; LoaderType the FSM encoding.
package Types;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;
endpackage

package LoaderType;
  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    BYTE,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

  localparam int LEN_BYTES = 2;
endpackage

// File: rtl/word_assembler.sv
// Big-endian word assembler: shifts bytes in from the right.
// full flags the shift that completes the current word.
module word_assembler
  import Types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic [7:0] byte_in,
  output inst_t      word,
  output logic       full
);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      word <= {word[23:0], byte_in};
      cnt  <= cnt + 2'd1;
    end
  end

  assign full = shift_en && (cnt == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot-time loader: length-prefixed byte stream into the fetcher's
// instruction store, holding the CPU in reset until the image is in.
module inst_loader
  import Types::*;
  import LoaderType::*;
#(
  parameter addr_t BASE_ADDR = 32'h0000_0000,
  parameter int    MAX_WORDS = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output addr_t      load_addr,
  output inst_t      load_inst,
  output logic       load,
  output logic       chip_select,
  output logic       cpu_rst,
  output logic       done,
  output logic       error
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  loader_state_t state, state_n;
  logic [7:0]    len_hi;
  logic [15:0]   remaining;
  logic [15:0]   count;
  logic          accept;
  logic          shift_en;
  logic          full;

  assign accept   = in_valid && in_ready;
  assign shift_en = accept && (state == BYTE);
  assign count    = {len_hi, in_data};

  word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .byte_in  (in_data),
    .word     (load_inst),
    .full     (full)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      LEN_HI: if (accept) state_n = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (count == 16'd0)
            state_n = DONE;
          else if ({16'd0, count} > MAX_W)
            state_n = ERROR;
          else
            state_n = BYTE;
        end
      end
      BYTE:  if (full) state_n = WRITE;
      WRITE: begin
        if (remaining == 16'd1)
          state_n = DONE;
        else
          state_n = BYTE;
      end
      DONE:  state_n = DONE;
      ERROR: state_n = ERROR;
      default: state_n = LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LEN_HI;
      len_hi    <= '0;
      remaining <= '0;
      load_addr <= BASE_ADDR;
    end else begin
      state <= state_n;
      if (accept && state == LEN_HI)
        len_hi <= in_data;
      if (accept && state == LEN_LO)
        remaining <= count;
      if (state == WRITE) begin
        load_addr <= load_addr + 32'd4;
        remaining <= remaining - 16'd1;
      end
    end
  end

  // Ready depends on state only; rst just masks it.
  assign in_ready = !rst &&
    (state == LEN_HI || state == LEN_LO || state == BYTE);

  assign load        = (state == WRITE);
  assign chip_select = (state == WRITE);
  assign cpu_rst     = (state != DONE);
  assign done        = (state == DONE);
  assign error       = (state == ERROR);

endmodule
